// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a 5-stage RV32 core. Resolves data hazards
//   by forwarding from M/W into E, stalls on load-use, flushes on taken
//   branches/jumps resolved in E, and holds a multi-cycle mul/div op in E for
//   exactly MULDIV_LATENCY cycles using a two-state FSM plus 8-bit countdown.
//   A saturating counter tracks the number of cycles in which the PC was held.
//
// Ports:
//   CLK, RST               clock (rising edge), synchronous active-high reset
//   Rs1D, Rs2D             source registers of the instruction in D
//   Rs1E, Rs2E, RdE        source/destination registers of the instruction in E
//   RdM, RegWriteM         destination/write-enable of the instruction in M
//   RdW, RegWriteW         destination/write-enable of the instruction in W
//   ResultSrcE             E result source (2'b01 = load)
//   PCSrcE                 branch taken / jump resolved in E
//   MulDivE                instruction in E is a mul/div
//   ForwardAE, ForwardBE   E operand select: 00 RD, 10 ALUResultM, 01 ResultW
//   StallF, StallD, StallE hold PC, F/D, D/E
//   FlushD, FlushE, FlushM clear F/D, D/E (CLR), E/M (bubble)
//   MulDivBusy             FSM is in BUSY (state observation point)
//   StallCycles            saturating count of cycles with StallF=1
//
// Handshake note: there is no valid/ready pairing here; every output is a
// level that the pipeline registers sample on the same rising edge.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int ADDRESS_WIDTH  = 5,
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [ADDRESS_WIDTH-1:0] RdE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcE,
    input  logic                     PCSrcE,
    input  logic                     MulDivE,
    output logic [1:0]               ForwardAE,
    output logic [1:0]               ForwardBE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushM,
    output logic                     MulDivBusy,
    output logic [CNT_WIDTH-1:0]     StallCycles
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // A latency of 1 means the op finishes in its first E cycle: no FSM needed.
    localparam bit         MD_EN    = (MULDIV_LATENCY > 1);
    // The IDLE cycle is the first of the op and the cnt==0 BUSY cycle the last,
    // so the countdown starts at LATENCY-2.
    localparam logic [7:0] CNT_INIT = MD_EN ? 8'(MULDIV_LATENCY - 2) : 8'd0;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

    logic [1:0]             fwd_a, fwd_b;
    logic                   lw_stall;
    logic                   md_stall;

    // ---------------------------------------------------------------- forwarding
    always_comb begin
        fwd_a = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
            fwd_a = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
            fwd_b = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
            fwd_b = 2'b01;
    end

    // ------------------------------------------------------------ hazard terms
    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    // The op is released (no stall) in the BUSY cycle that sees cnt==0.
    assign md_stall = MulDivE && MD_EN &&
                      (((state_q == S_IDLE) && !PCSrcE) ||
                       ((state_q == S_BUSY) && (cnt_q != 8'd0)));

    // ------------------------------------------------------------ FSM: next
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (PCSrcE) begin
            // A redirect squashes whatever is in E, including a mul/div.
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (MulDivE && MD_EN) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 8'd0)
                        state_d = S_IDLE;
                    else
                        cnt_d = cnt_q - 8'd1;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        if (RST) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (md_stall) begin
                // Freeze the front end and feed bubbles into M while E is busy.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign MulDivBusy  = (state_q == S_BUSY);
    assign StallCycles = stall_cnt_q;

    // ------------------------------------------------------------ stall counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       CLK;
  logic       RST;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MulDivE, sat_mde;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy;
  logic [31:0] StallCycles;

  logic [1:0]  s_fa, s_fb;
  logic        s_sf, s_sd, s_se, s_fd, s_fe, s_fm, s_busy;
  logic [3:0]  s_sc;

  wire [5:0] ctl   = {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  wire [5:0] s_ctl = {s_sf, s_sd, s_se, s_fd, s_fe, s_fm};

  hazard_ctrl #(.ADDRESS_WIDTH(5), .MULDIV_LATENCY(4), .CNT_WIDTH(32)) u_dut (
    .CLK(CLK), .RST(RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
  );

  // Latency-1, 4-bit-counter variant: no mul/div FSM, fast saturation.
  hazard_ctrl #(.ADDRESS_WIDTH(5), .MULDIV_LATENCY(1), .CNT_WIDTH(4)) u_sat (
    .CLK(CLK), .RST(RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivE(sat_mde),
    .ForwardAE(s_fa), .ForwardBE(s_fb),
    .StallF(s_sf), .StallD(s_sd), .StallE(s_se),
    .FlushD(s_fd), .FlushE(s_fe), .FlushM(s_fm),
    .MulDivBusy(s_busy), .StallCycles(s_sc)
  );

  // ---------------------------------------------------------------- clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- checking
  int n_chk = 0;
  int n_err = 0;
  int exp_sc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
    RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; MulDivE = 0; sat_mde = 0;
  endtask

  // ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LW   = 6'b110010;
  localparam logic [5:0] C_BR   = 6'b000110;
  localparam logic [5:0] C_MD   = 6'b111001;
  localparam logic [5:0] C_RST  = 6'b000111;

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rse;
    logic       pcs, mde;
    logic [1:0] fa, fb;
    logic [5:0] ctl;
  } vec_t;

  vec_t vecs[13];

  // One mul/div run of LATENCY=4 held for n cycles; ops repeat every 4 cycles.
  task automatic run_md(input string tag, input int n);
    MulDivE = 1;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      check({tag, "_ctl"}, 32'(ctl), ((k % 4) < 3) ? 32'(C_MD) : 32'(C_NONE));
      check({tag, "_busy"}, 32'(MulDivBusy), ((k % 4) >= 1) ? 32'd1 : 32'd0);
      if ((k % 4) < 3) exp_sc++;
      step();
    end
    MulDivE = 0;
    @(negedge CLK);
    check({tag, "_busy_after"}, 32'(MulDivBusy), 32'd0);
    check({tag, "_stallcycles"}, StallCycles, 32'(exp_sc));
    step();
  endtask

  initial begin
    //               name        rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rse   pcs mde fa     fb     ctl
    vecs[0]  = '{"fwdA_M",       0,   0,   5,   0,   0,  5,  5,  1,  1,  2'b00, 0, 0, 2'b10, 2'b00, C_NONE};
    vecs[1]  = '{"fwdA_W",       0,   0,   5,   0,   0,  0,  5,  1,  1,  2'b00, 0, 0, 2'b01, 2'b00, C_NONE};
    vecs[2]  = '{"fwdA_none",    0,   0,   5,   0,   0,  0,  5,  1,  0,  2'b00, 0, 0, 2'b00, 2'b00, C_NONE};
    vecs[3]  = '{"fwd_mixed",    0,   0,   3,   9,   0,  9,  3,  1,  1,  2'b00, 0, 0, 2'b01, 2'b10, C_NONE};
    vecs[4]  = '{"fwd_x0",       0,   0,   0,   9,   0,  0,  0,  1,  1,  2'b00, 0, 0, 2'b00, 2'b00, C_NONE};
    vecs[5]  = '{"lw_rs2",       0,   7,   0,   0,   7,  0,  0,  0,  0,  2'b01, 0, 0, 2'b00, 2'b00, C_LW};
    vecs[6]  = '{"lw_rd0",       0,   0,   0,   0,   0,  0,  0,  0,  0,  2'b01, 0, 0, 2'b00, 2'b00, C_NONE};
    vecs[7]  = '{"lw_rs1",       7,   0,   0,   0,   7,  0,  0,  0,  0,  2'b01, 0, 0, 2'b00, 2'b00, C_LW};
    vecs[8]  = '{"notload",      7,   0,   0,   0,   7,  0,  0,  0,  0,  2'b10, 0, 0, 2'b00, 2'b00, C_NONE};
    vecs[9]  = '{"branch",       0,   0,   0,   0,   0,  0,  0,  0,  0,  2'b00, 1, 0, 2'b00, 2'b00, C_BR};
    vecs[10] = '{"branch_lw",    7,   0,   0,   0,   7,  0,  0,  0,  0,  2'b01, 1, 0, 2'b00, 2'b00, C_BR};
    vecs[11] = '{"branch_md",    0,   0,   0,   0,   0,  0,  0,  0,  0,  2'b00, 1, 1, 2'b00, 2'b00, C_BR};
    vecs[12] = '{"idle_after",   0,   0,   0,   0,   0,  0,  0,  0,  0,  2'b00, 0, 0, 2'b00, 2'b00, C_NONE};

    // ------------------------------------------------------------ reset
    clear_inputs();
    RST = 1;
    Rs1E = 5; RdM = 5; RegWriteM = 1; PCSrcE = 1;
    @(negedge CLK);
    check("rst_ctl", 32'(ctl), 32'(C_RST));
    check("rst_fwdA", 32'(ForwardAE), 32'd0);
    step();
    step();
    RST = 0;
    clear_inputs();
    @(negedge CLK);
    check("post_rst_ctl", 32'(ctl), 32'(C_NONE));
    check("post_rst_busy", 32'(MulDivBusy), 32'd0);
    check("post_rst_sc", StallCycles, 32'd0);
    step();

    // ------------------------------------------------------------ table
    for (int i = 0; i < 13; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d;
      Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      ResultSrcE = vecs[i].rse; PCSrcE = vecs[i].pcs; MulDivE = vecs[i].mde;
      @(negedge CLK);
      check({vecs[i].name, "_fa"}, 32'(ForwardAE), 32'(vecs[i].fa));
      check({vecs[i].name, "_fb"}, 32'(ForwardBE), 32'(vecs[i].fb));
      check({vecs[i].name, "_ctl"}, 32'(ctl), 32'(vecs[i].ctl));
      check({vecs[i].name, "_busy"}, 32'(MulDivBusy), 32'd0);
      if (vecs[i].ctl[5]) exp_sc++;
      step();
    end
    clear_inputs();
    @(negedge CLK);
    check("table_sc", StallCycles, 32'(exp_sc));
    step();

    // ------------------------------------------------------------ mul/div
    run_md("md_single", 4);
    run_md("md_b2b", 8);

    // Branch resolved while BUSY squashes the op.
    MulDivE = 1;
    @(negedge CLK);
    check("mdbr_c0_ctl", 32'(ctl), 32'(C_MD));
    exp_sc++;
    step();
    PCSrcE = 1;
    @(negedge CLK);
    check("mdbr_c1_ctl", 32'(ctl), 32'(C_BR));
    check("mdbr_c1_busy", 32'(MulDivBusy), 32'd1);
    step();
    PCSrcE = 0; MulDivE = 0;
    @(negedge CLK);
    check("mdbr_c2_busy", 32'(MulDivBusy), 32'd0);
    check("mdbr_c2_ctl", 32'(ctl), 32'(C_NONE));
    check("mdbr_sc", StallCycles, 32'(exp_sc));
    step();

    // ------------------------------------------------------------ reset mid-op
    MulDivE = 1;
    @(negedge CLK);
    check("rstmd_c0_ctl", 32'(ctl), 32'(C_MD));
    step();
    RST = 1;
    @(negedge CLK);
    check("rstmd_c1_ctl", 32'(ctl), 32'(C_RST));
    check("rstmd_c1_busy", 32'(MulDivBusy), 32'd1);
    step();
    RST = 0; MulDivE = 0;
    exp_sc = 0;
    @(negedge CLK);
    check("rstmd_c2_busy", 32'(MulDivBusy), 32'd0);
    check("rstmd_c2_ctl", 32'(ctl), 32'(C_NONE));
    check("rstmd_c2_sc", StallCycles, 32'd0);
    check("rstmd_sat_sc", 32'(s_sc), 32'd0);
    step();

    // ------------------------------------------------------------ saturation
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      check("sat_hold_sc", 32'(s_sc), (k < 15) ? 32'(k) : 32'd15);
      check("sat_hold_ctl", 32'(s_ctl), 32'(C_LW));
      exp_sc++;
      step();
    end
    clear_inputs();
    @(negedge CLK);
    check("sat_final_sc", 32'(s_sc), 32'd15);
    check("sat_wide_sc", StallCycles, 32'(exp_sc));
    step();

    // Latency-1 mul/div never stalls nor goes busy.
    sat_mde = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("lat1_ctl", 32'(s_ctl), 32'(C_NONE));
      check("lat1_busy", 32'(s_busy), 32'd0);
      step();
    end
    sat_mde = 0;
    @(negedge CLK);
    check("lat1_sc_stays", 32'(s_sc), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32 core. It drives the stall and flush inputs of the F/D, D/E (CLR) and E/M pipeline registers, and the E-stage operand forwarding muxes. It detects load-use and control hazards, and sequences multi-cycle mul/div operations in E with an internal FSM and latency counter. It also keeps a saturating stall-cycle performance counter.

Parameters:
ADDRESS_WIDTH, 5, register index width
MULDIV_LATENCY, 4, total E-stage cycles for a mul/div op (legal range 1..255)
CNT_WIDTH, 32, width of the stall-cycle counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
Rs1D  input  ADDRESS_WIDTH  rs1 index of the instruction in D
Rs2D  input  ADDRESS_WIDTH  rs2 index of the instruction in D
Rs1E  input  ADDRESS_WIDTH  rs1 index of the instruction in E
Rs2E  input  ADDRESS_WIDTH  rs2 index of the instruction in E
RdE  input  ADDRESS_WIDTH  rd index of the instruction in E
RdM  input  ADDRESS_WIDTH  rd index of the instruction in M
RdW  input  ADDRESS_WIDTH  rd index of the instruction in W
RegWriteM  input  1  M-stage instruction writes rd
RegWriteW  input  1  W-stage instruction writes rd
ResultSrcE  input  2  E-stage result source; 2'b01 = load
PCSrcE  input  1  branch taken or jump resolved in E
MulDivE  input  1  E-stage instruction is a mul/div
ForwardAE  output  2  SrcA select: 00 = RD1E, 10 = ALUResultM, 01 = ResultW
ForwardBE  output  2  SrcB select, same encoding as ForwardAE
StallF  output  1  hold PC
StallD  output  1  hold F/D register
StallE  output  1  hold D/E register
FlushD  output  1  clear F/D register
FlushE  output  1  clear D/E register (drives CLR)
FlushM  output  1  clear E/M register (insert bubble)
MulDivBusy  output  1  FSM in BUSY
StallCycles  output  CNT_WIDTH  count of cycles with StallF=1

Behaviour:
- Forwarding (combinational), ForwardAE:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M takes priority over W. ForwardBE is identical using Rs2E.
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
- FSM states: IDLE and BUSY. Counter cnt is 8 bits.
  - IDLE: if MulDivE && !PCSrcE && MULDIV_LATENCY>1, go to BUSY with cnt = MULDIV_LATENCY-2. Otherwise stay in IDLE.
  - BUSY: if cnt==0, go to IDLE. Otherwise cnt decrements by 1.
- mdStall = MulDivE && MULDIV_LATENCY>1 && ((IDLE && !PCSrcE) || (BUSY && cnt!=0)).
  - Result: a mul/div occupies E for exactly MULDIV_LATENCY cycles and advances in the cycle BUSY sees cnt==0.
- Output priority (combinational), highest first:
  1. RST: FlushD=FlushE=FlushM=1, all stalls 0, forwards 00.
  2. PCSrcE: FlushD=FlushE=1. Stalls 0, FlushM=0. The FSM is forced to IDLE next cycle.
  3. mdStall: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0.
  4. lwStall: StallF=StallD=1, FlushE=1.
  5. Otherwise all stalls and flushes are 0.
- lwStall and mdStall are mutually exclusive by construction (a load is not a mul/div). If both assert, mdStall wins.
- MulDivBusy = (state==BUSY).
- StallCycles:
  - Increments by 1 on each rising edge where StallF=1.
  - Saturates at all-ones.
  - Cleared only by RST.
- Reset (synchronous): state=IDLE, cnt=0, StallCycles=0. Reset asserted mid-BUSY aborts the op; the next cycle is IDLE with no stall.
- MULDIV_LATENCY=1: the FSM never leaves IDLE and mdStall is constantly 0.
- Back-to-back mul/div: the second op enters E in the cycle after release. It is seen in IDLE and starts a new sequence with no gap cycle.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Repeat with RdM=0 -> ForwardAE=01. Repeat with RegWriteW=0 -> ForwardAE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 for 1 cycle -> StallF=StallD=FlushE=1 that cycle only, StallCycles increments 0->1. With RdE=0 -> no stall.
- Mul/div, MULDIV_LATENCY=4: MulDivE held high for 4 cycles -> StallF/StallD/StallE/FlushM=1 for cycles 0-2 and 0 on cycle 3. MulDivBusy=1 on cycles 1-3. StallCycles=3.
- Branch: PCSrcE=1 -> FlushD=FlushE=1, no stall. PCSrcE and MulDivE both high in IDLE -> flush only, FSM stays IDLE.
- Reset mid-op: RST=1 on cycle 1 of a 4-cycle mul/div -> next cycle state IDLE, MulDivBusy=0, StallCycles=0. While RST=1, FlushD=FlushE=FlushM=1.
- Saturation: preload by holding a stall with CNT_WIDTH=4 for 20 cycles -> StallCycles=15 and stays 15.
